// File: rtl/dot_product_unit_pkg.sv
// ============================================================================
// dot_product_unit_pkg : shared widths and sum-width helper for the dot-product unit
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_product_unit_pkg;

  localparam int ELEM_W = 8;
  localparam int RES_W  = 16;

  // Width of the full-precision sum of SIZE unsigned 16-bit products.
  function automatic int sum_width(input int size);
    return RES_W + $clog2(size);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_unit_adder_tree.sv
// ============================================================================
// dp_adder_tree : combinational reduction of SIZE 16-bit products to a full-width sum
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_adder_tree
  import dot_product_unit_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0][RES_W-1:0]    products,
  output logic [sum_width(SIZE)-1:0]    sum
);

  localparam int SUM_W = sum_width(SIZE);

  always_comb begin
    sum = '0;
    for (int i = 0; i < SIZE; i++) begin
      sum = sum + SUM_W'(products[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dot_product_unit.sv
// ============================================================================
// dot_product_unit : two-stage pipelined unsigned 8-bit dot product, 16-bit result + overflow
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_unit
  import dot_product_unit_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ELEM_W*SIZE-1:0]   a,
  input  logic [ELEM_W*SIZE-1:0]   b,
  output logic                     out_valid,
  output logic [RES_W-1:0]         result,
  output logic                     overflow
);

  localparam int SUM_W = sum_width(SIZE);

  logic [SIZE-1:0][RES_W-1:0] prod_next;
  logic [SIZE-1:0][RES_W-1:0] prod_q;
  logic                       valid_q;
  logic [SUM_W-1:0]           sum;
  logic                       sum_ovf;

  generate
    for (genvar i = 0; i < SIZE; i++) begin : g_mul
      assign prod_next[i] = RES_W'(a[i*ELEM_W +: ELEM_W]) * RES_W'(b[i*ELEM_W +: ELEM_W]);
    end
  endgenerate

  // Stage 1: products only load on accepted pairs so idle data cannot leak through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        prod_q <= prod_next;
      end
    end
  end

  dp_adder_tree #(
    .SIZE (SIZE)
  ) u_adder_tree (
    .products (prod_q),
    .sum      (sum)
  );

  generate
    if (SUM_W > RES_W) begin : g_ovf
      assign sum_ovf = |sum[SUM_W-1:RES_W];
    end else begin : g_no_ovf
      assign sum_ovf = 1'b0;
    end
  endgenerate

  // Stage 2: result/overflow hold between valid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= valid_q;
      if (valid_q) begin
        result   <= sum[RES_W-1:0];
        overflow <= sum_ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_product_unit.sv
// ============================================================================
// tb_dot_product_unit : scoreboard-based self-checking bench for dot_product_unit (SIZE=4)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_product_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [15:0] result;
  logic        overflow;

  dot_product_unit #(.SIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] r;
    logic        o;
  } exp_t;

  typedef struct {
    logic        v;
    logic [31:0] x;
    logic [31:0] y;
  } stim_t;

  exp_t        sb[$];
  stim_t       stim[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] held_r = '0;
  logic        held_o = 1'b0;

  function automatic exp_t model(input logic v, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    int unsigned s = 0;
    for (int k = 0; k < 4; k++) s += x[8*k +: 8] * y[8*k +: 8];
    e.v = v;
    e.r = s[15:0];
    e.o = (s > 32'h0000_FFFF);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y);
    in_valid = v;
    a        = x;
    b        = y;
    sb.push_back(model(v, x, y));
  endtask

  task automatic add_stim(input logic v, input logic [31:0] x, input logic [31:0] y);
    stim_t s;
    s.v = v; s.x = x; s.y = y;
    stim.push_back(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    held_r = '0;
    held_o = 1'b0;
  endtask

  task automatic test_single_pulses();
    exp_t e;
    logic ev;
    int   n;
    add_stim(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});  // 70
    add_stim(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    add_stim(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    add_stim(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);                         // 63492, ovf
    add_stim(1'b0, 32'h0, 32'h0);
    add_stim(1'b0, 32'h0, 32'h0);
    add_stim(1'b1, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd2}); // 510
    add_stim(1'b0, 32'h0, 32'h0);
    add_stim(1'b0, 32'h0, 32'h0);
    add_stim(1'b1, 32'h0, 32'hA5C3_96E1);                                  // 0
    n = stim.size();
    for (int c = 0; c < n + 2; c++) begin
      if (stim.size() > 0) begin stim_t s = stim.pop_front(); drive(s.v, s.x, s.y); end
      else drive(1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      ev = 1'b0;
      if (sb.size() == 2) begin
        e = sb.pop_front();
        ev = e.v;
        if (e.v) begin held_r = e.r; held_o = e.o; end
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL single_out_valid cyc %0d got %0b want %0b", c, out_valid, ev); end
      checks++; if (result !== held_r) begin errors++; $display("FAIL single_result cyc %0d got %0d want %0d", c, result, held_r); end
      checks++; if (overflow !== held_o) begin errors++; $display("FAIL single_overflow cyc %0d got %0b want %0b", c, overflow, held_o); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic ev;
    int   n;
    add_stim(1'b1, {8'd10, 8'd20, 8'd30, 8'd40}, {8'd1, 8'd2, 8'd3, 8'd4});
    add_stim(1'b1, {8'd200, 8'd100, 8'd50, 8'd25}, {8'd9, 8'd8, 8'd7, 8'd6});
    add_stim(1'b1, {8'd128, 8'd128, 8'd128, 8'd128}, {8'd128, 8'd128, 8'd128, 8'd128});
    add_stim(1'b1, {8'd1, 8'd0, 8'd0, 8'd0}, {8'd255, 8'd0, 8'd0, 8'd0});
    add_stim(1'b0, 32'h5555_AAAA, 32'hAAAA_5555);
    n = stim.size();
    for (int c = 0; c < n + 2; c++) begin
      if (stim.size() > 0) begin stim_t s = stim.pop_front(); drive(s.v, s.x, s.y); end
      else drive(1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      ev = 1'b0;
      if (sb.size() == 2) begin
        e = sb.pop_front();
        ev = e.v;
        if (e.v) begin held_r = e.r; held_o = e.o; end
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL b2b_out_valid cyc %0d got %0b want %0b", c, out_valid, ev); end
      checks++; if (result !== held_r) begin errors++; $display("FAIL b2b_result cyc %0d got %0d want %0d", c, result, held_r); end
      checks++; if (overflow !== held_o) begin errors++; $display("FAIL b2b_overflow cyc %0d got %0b want %0b", c, overflow, held_o); end
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    logic ev;
    int   n;
    add_stim(1'b1, {8'd7, 8'd7, 8'd7, 8'd7}, {8'd9, 8'd9, 8'd9, 8'd9});
    for (int k = 0; k < 6; k++) add_stim(1'b0, $urandom, $urandom);
    n = stim.size();
    for (int c = 0; c < n + 2; c++) begin
      if (stim.size() > 0) begin stim_t s = stim.pop_front(); drive(s.v, s.x, s.y); end
      else drive(1'b0, $urandom, $urandom);
      @(posedge clk); #1;
      ev = 1'b0;
      if (sb.size() == 2) begin
        e = sb.pop_front();
        ev = e.v;
        if (e.v) begin held_r = e.r; held_o = e.o; end
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL bubble_out_valid cyc %0d got %0b want %0b", c, out_valid, ev); end
      checks++; if (result !== held_r) begin errors++; $display("FAIL bubble_result cyc %0d got %0d want %0d", c, result, held_r); end
      checks++; if (overflow !== held_o) begin errors++; $display("FAIL bubble_overflow cyc %0d got %0b want %0b", c, overflow, held_o); end
    end
  endtask

  task automatic test_random_stream();
    exp_t e;
    logic ev;
    int   n;
    for (int k = 0; k < 40; k++) add_stim(1'($urandom_range(0, 3) != 0), $urandom, $urandom);
    n = stim.size();
    for (int c = 0; c < n + 2; c++) begin
      if (stim.size() > 0) begin stim_t s = stim.pop_front(); drive(s.v, s.x, s.y); end
      else drive(1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      ev = 1'b0;
      if (sb.size() == 2) begin
        e = sb.pop_front();
        ev = e.v;
        if (e.v) begin held_r = e.r; held_o = e.o; end
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL rand_out_valid cyc %0d got %0b want %0b", c, out_valid, ev); end
      checks++; if (result !== held_r) begin errors++; $display("FAIL rand_result cyc %0d got %0d want %0d", c, result, held_r); end
      checks++; if (overflow !== held_o) begin errors++; $display("FAIL rand_overflow cyc %0d got %0b want %0b", c, overflow, held_o); end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    logic ev;
    int   n;
    add_stim(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add_stim(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    add_stim(1'b1, 32'hFFFF_FFFF, 32'h0101_0101);
    // Run only the three edges: pair 0 emerged, pair 1 at output, pair 2 in stage 1.
    for (int c = 0; c < 3; c++) begin
      stim_t s = stim.pop_front();
      drive(s.v, s.x, s.y);
      @(posedge clk); #1;
      ev = 1'b0;
      if (sb.size() == 2) begin
        e = sb.pop_front();
        ev = e.v;
        if (e.v) begin held_r = e.r; held_o = e.o; end
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL mid_pre_out_valid cyc %0d got %0b want %0b", c, out_valid, ev); end
      checks++; if (result !== held_r) begin errors++; $display("FAIL mid_pre_result cyc %0d got %0d want %0d", c, result, held_r); end
    end
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %0b want 0", out_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mid_reset_result got %0d want 0", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow got %0b want 0", overflow); end
    sb.delete();
    held_r = '0;
    held_o = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    add_stim(1'b0, 32'h0, 32'h0);
    add_stim(1'b0, 32'h0, 32'h0);
    add_stim(1'b1, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd2});
    n = stim.size();
    for (int c = 0; c < n + 2; c++) begin
      if (stim.size() > 0) begin stim_t s = stim.pop_front(); drive(s.v, s.x, s.y); end
      else drive(1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      ev = 1'b0;
      if (sb.size() == 2) begin
        e = sb.pop_front();
        ev = e.v;
        if (e.v) begin held_r = e.r; held_o = e.o; end
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL mid_post_out_valid cyc %0d got %0b want %0b", c, out_valid, ev); end
      checks++; if (result !== held_r) begin errors++; $display("FAIL mid_post_result cyc %0d got %0d want %0d", c, result, held_r); end
      checks++; if (overflow !== held_o) begin errors++; $display("FAIL mid_post_overflow cyc %0d got %0b want %0b", c, overflow, held_o); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulses();
    test_back_to_back();
    test_bubbles();
    test_random_stream();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
